aes_iter_core: RTL and testbench
================================

# aes_iter_core

Iterative, parametrised AES block-cipher core: one round per clock, AES-128/192/256 selected by parameter, encrypt or decrypt selected per block. It replaces stacks of hard-wired single-round instances and sits between the key-schedule store and the mode/stream layer. The core has valid/ready handshakes on both sides and holds one block in flight.

## Interface
- KEY_BITS, 128: 128, 192 or 256. Any other value is an elaboration error. NR = 10/12/14.
- RKW, derived: (NR+1)*128, width of the packed round-key bus.
- clk  in  1  clock, rising edge.
- rst  in  1  reset; asynchronous and active-high.
- in_valid  in  1  block offered.
- in_ready  out  1  core can accept; equals (state==IDLE).
- in_decrypt  in  1  0 = encrypt, 1 = decrypt; sampled at accept.
- in_block  in  128  plaintext/ciphertext; byte 0 = [127:120], FIPS-197 column-major.
- rk  in  RKW  round keys; rk[r] = rk[128*r +: 128]; sampled at accept and held internally.
- out_valid  out  1  result available.
- out_ready  in  1  downstream accepts.
- out_block  out  128  result; stable while out_valid.
- busy  out  1  state != IDLE.

## Operation
- States: IDLE, RUN, DONE.
- Reset (async): state=IDLE, round counter=0, state register=0, out_valid=0, out_block=0, busy=0. in_ready=1 from reset onward.
- IDLE, in_valid&in_ready: latch mode and rk. Load state register with in_block ^ rk[0] (enc) or in_block ^ rk[NR] (dec). Counter=1. Go to RUN.
- Encrypt round r=1..NR-1: SubBytes, ShiftRows, MixColumns, AddRoundKey rk[r]. Round NR omits MixColumns.
- Decrypt, equivalent inverse cipher, round index k=1..NR using key rk[NR-k]: InvSubBytes, InvShiftRows, InvMixColumns, AddRoundKey. Round k=NR omits InvMixColumns and uses rk[0].
- Key-store contract: for decryption, rk[1..NR-1] arrive pre-transformed by InvMixColumns. The core never transforms keys.
- RUN: apply one round per cycle and increment the counter. When counter==NR, the update writes out_block, sets out_valid and goes to DONE.
- DONE: hold out_block and out_valid. On out_ready: out_valid<=0, go to IDLE. No accept while DONE.
- Counter width: $clog2(NR+1). It never exceeds NR.
- rst mid-RUN or mid-DONE: block is discarded, no output, all state as at reset.
- in_decrypt, in_block and rk changes after accept have no effect.

## Timing
- Accept at edge T0. out_valid rises after edge T0+NR; latency is NR cycles.
- Earliest next accept: the edge after the output handshake, so throughput is one block per NR+2 cycles with out_ready held high.
- in_ready is combinational from state only, with no path from in_valid. out_valid and out_block are registered.
- The critical path is one full round: S-box, MixColumns, key XOR, plus the enc/dec mux.

## Structure
- Shared package aes_pkg holds:
  - the state enum {IDLE, RUN, DONE};
  - function nr(KEY_BITS);
  - the round-counter width;
  - the FIPS test vectors used by the bench.
- One sub-module, aes_round_unit: combinational, inputs state, key, decrypt, last. It instantiates the existing SubBytes/InvSubBytes, ShiftRows/InvShiftRows, MixColumns/InvMixColumns and AddRoundKey blocks, muxes on decrypt and bypasses (Inv)MixColumns when last.
- The top level holds the FSM, counter, key registers and output register.

## Test plan
- AES-128 encrypt: pt 00112233445566778899aabbccddeeff, key 000102…0f -> out_block 69c4e0d86a7b0430d8cdb78070b4c55a exactly 10 cycles after accept.
- AES-128 decrypt of 69c4e0d8… with equivalent-inverse keys -> 00112233…eeff.
- AES-192 (key 00…17) and AES-256 (key 00…1f), both directions -> dda97ca4864cdfe06eaf70a0ec0d7191 and 8ea2b7ca516745bfeafc49904b496089; latency 12 and 14 cycles.
- Backpressure:
  - out_ready low for 5 cycles after out_valid -> out_block stable, in_ready=0;
  - raising out_ready -> in_ready=1 the next cycle;
  - back-to-back enc then dec blocks -> both correct.
- Assert rst during RUN at round 4 -> out_valid stays 0, busy=0, in_ready=1. A fresh block afterwards gives the correct result.
- Change in_block, in_decrypt and rk on every cycle after accept -> the result matches the values sampled at accept.

Source files
------------

// File: rtl/aes_pkg.sv
`default_nettype none
// ============================================================================
// aes_pkg: FSM state type, round-count helpers, AES byte transforms, FIPS-197 vectors
// Revision: 1.0
// ============================================================================
package aes_pkg;

    typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_e;

    function automatic int nr(input int key_bits);
        return key_bits / 32 + 6;
    endfunction

    function automatic int ctr_width(input int key_bits);
        return $clog2(nr(key_bits) + 1);
    endfunction

    localparam logic [127:0] FIPS_PT    = 128'h00112233445566778899aabbccddeeff;
    localparam logic [255:0] FIPS_KEY   = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
    localparam logic [127:0] FIPS_CT128 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] FIPS_CT192 = 128'hdda97ca4864cdfe06eaf70a0ec0d7191;
    localparam logic [127:0] FIPS_CT256 = 128'h8ea2b7ca516745bfeafc49904b496089;

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    // Multiplicative inverse as a^254; maps 0 to 0 as the S-box requires.
    function automatic logic [7:0] gf_inv(input logic [7:0] a);
        logic [7:0] r;
        logic [7:0] p;
        r = 8'h01;
        p = a;
        for (int i = 1; i < 8; i++) begin
            p = gf_mul(p, p);
            r = gf_mul(r, p);
        end
        return r;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] x, input int n);
        return (x << n) | (x >> (8 - n));
    endfunction

    function automatic logic [7:0] sbox(input logic [7:0] b);
        logic [7:0] i;
        i = gf_inv(b);
        return i ^ rotl8(i, 1) ^ rotl8(i, 2) ^ rotl8(i, 3) ^ rotl8(i, 4) ^ 8'h63;
    endfunction

    function automatic logic [7:0] inv_sbox(input logic [7:0] b);
        return gf_inv(rotl8(b, 1) ^ rotl8(b, 3) ^ rotl8(b, 6) ^ 8'h05);
    endfunction

    function automatic logic [127:0] sub_bytes(input logic [127:0] s, input logic inv);
        logic [127:0] o;
        for (int i = 0; i < 16; i++)
            o[127-8*i -: 8] = inv ? inv_sbox(s[127-8*i -: 8]) : sbox(s[127-8*i -: 8]);
        return o;
    endfunction

    // Byte 4*c+r holds row r of column c.
    function automatic logic [127:0] shift_rows(input logic [127:0] s, input logic inv);
        logic [127:0] o;
        int src;
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++) begin
                src = inv ? ((c - r + 4) % 4) : ((c + r) % 4);
                o[127-8*(4*c+r) -: 8] = s[127-8*(4*src+r) -: 8];
            end
        return o;
    endfunction

    function automatic logic [127:0] mix_columns(input logic [127:0] s, input logic inv);
        logic [127:0] o;
        logic [7:0]   m [4];
        logic [7:0]   acc;
        m[0] = inv ? 8'd14 : 8'd2;
        m[1] = inv ? 8'd11 : 8'd3;
        m[2] = inv ? 8'd13 : 8'd1;
        m[3] = inv ? 8'd9  : 8'd1;
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++) begin
                acc = 8'h00;
                for (int j = 0; j < 4; j++)
                    acc = acc ^ gf_mul(m[(j - r + 4) % 4], s[127-8*(4*c+j) -: 8]);
                o[127-8*(4*c+r) -: 8] = acc;
            end
        return o;
    endfunction

endpackage
`default_nettype wire

// File: rtl/aes_round_unit.sv
`default_nettype none
// ============================================================================
// aes_round_unit: one combinational AES round, forward or equivalent-inverse
// Revision: 1.0
// ============================================================================
module aes_round_unit
    import aes_pkg::*;
(
    input  logic [127:0] state_i,
    input  logic [127:0] key_i,
    input  logic         decrypt_i,
    input  logic         last_i,
    output logic [127:0] state_o
);

    logic [127:0] w_fwd;
    logic [127:0] w_inv;
    logic [127:0] w_fwd_mix;
    logic [127:0] w_inv_mix;
    logic [127:0] w_sel;

    // Both directions use fixed-coefficient MixColumns so each stays constant-multiplier logic.
    always_comb begin
        w_fwd     = shift_rows(sub_bytes(state_i, 1'b0), 1'b0);
        w_inv     = sub_bytes(shift_rows(state_i, 1'b1), 1'b1);
        w_fwd_mix = mix_columns(w_fwd, 1'b0);
        w_inv_mix = mix_columns(w_inv, 1'b1);
        if (decrypt_i) w_sel = last_i ? w_inv : w_inv_mix;
        else           w_sel = last_i ? w_fwd : w_fwd_mix;
        state_o = w_sel ^ key_i;
    end

endmodule
`default_nettype wire

// File: rtl/aes_iter_core.sv
`default_nettype none
// ============================================================================
// aes_iter_core: iterative AES-128/192/256 core, one round per clock, one block in flight
// Revision: 1.0
// ============================================================================
module aes_iter_core
    import aes_pkg::*;
#(
    parameter  int KEY_BITS = 128,
    localparam int NR       = nr(KEY_BITS),
    localparam int RKW      = (NR + 1) * 128
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             in_decrypt,
    input  logic [127:0]     in_block,
    input  logic [RKW-1:0]   rk,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [127:0]     out_block,
    output logic             busy
);

    localparam int            CW   = ctr_width(KEY_BITS);
    localparam logic [CW-1:0] NR_C = CW'(NR);

    if (KEY_BITS != 128 && KEY_BITS != 192 && KEY_BITS != 256) begin : g_bad_key_bits
        $error("aes_iter_core: KEY_BITS must be 128, 192 or 256");
    end

    state_e         state_q, state_d;
    logic [CW-1:0]  ctr_q, ctr_d;
    logic [127:0]   blk_q, blk_d;
    logic [RKW-1:0] rk_q, rk_d;
    logic           dec_q, dec_d;
    logic [127:0]   out_block_q, out_block_d;
    logic           out_valid_q, out_valid_d;

    logic [CW-1:0]  w_ridx;
    logic [127:0]   w_key;
    logic [127:0]   w_round;
    logic           w_last;

    // Decrypt walks the schedule backwards: round k uses rk[NR-k].
    assign w_ridx = dec_q ? (NR_C - ctr_q) : ctr_q;
    assign w_key  = rk_q[128*w_ridx +: 128];
    assign w_last = (ctr_q == NR_C);

    aes_round_unit u_round (
        .state_i   (blk_q),
        .key_i     (w_key),
        .decrypt_i (dec_q),
        .last_i    (w_last),
        .state_o   (w_round)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            ctr_q       <= '0;
            blk_q       <= '0;
            rk_q        <= '0;
            dec_q       <= 1'b0;
            out_block_q <= '0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            ctr_q       <= ctr_d;
            blk_q       <= blk_d;
            rk_q        <= rk_d;
            dec_q       <= dec_d;
            out_block_q <= out_block_d;
            out_valid_q <= out_valid_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        ctr_d       = ctr_q;
        blk_d       = blk_q;
        rk_d        = rk_q;
        dec_d       = dec_q;
        out_block_d = out_block_q;
        out_valid_d = out_valid_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    dec_d   = in_decrypt;
                    rk_d    = rk;
                    blk_d   = in_block ^ (in_decrypt ? rk[128*NR +: 128] : rk[127:0]);
                    ctr_d   = {{(CW-1){1'b0}}, 1'b1};
                    state_d = RUN;
                end
            end
            RUN: begin
                blk_d = w_round;
                if (w_last) begin
                    out_block_d = w_round;
                    out_valid_d = 1'b1;
                    ctr_d       = '0;
                    state_d     = DONE;
                end else begin
                    ctr_d = ctr_q + 1'b1;
                end
            end
            DONE: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign in_ready  = (state_q == IDLE);
    assign busy      = (state_q != IDLE);
    assign out_valid = out_valid_q;
    assign out_block = out_block_q;

endmodule
`default_nettype wire

// File: tb/tb_aes_iter_core.sv
`default_nettype none
// ============================================================================
// tb_aes_iter_core: directed + randomized checks of AES-128/192/256 cores against a byte-level model
// Revision: 1.0
// ============================================================================
module tb_aes_iter_core;
    import aes_pkg::*;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic [2:0]      in_valid = '0;
    logic [2:0]      in_ready, out_valid, busy;
    logic            in_decrypt = 1'b0;
    logic [127:0]    in_block = '0;
    logic [1919:0]   rk_bus = '0;
    logic            out_ready = 1'b1;
    logic [127:0]    out_block [3];

    int checks = 0;
    int errors = 0;

    logic [7:0]   sbx  [256];
    logic [7:0]   isbx [256];
    logic [127:0] rkeys [15];

    always #5 clk = ~clk;

    for (genvar k = 0; k < 3; k++) begin : g_dut
        localparam int KB = 128 + 64 * k;
        localparam int RW = (KB / 32 + 7) * 128;
        aes_iter_core #(.KEY_BITS(KB)) u_dut (
            .clk        (clk),
            .rst        (rst),
            .in_valid   (in_valid[k]),
            .in_ready   (in_ready[k]),
            .in_decrypt (in_decrypt),
            .in_block   (in_block),
            .rk         (rk_bus[RW-1:0]),
            .out_valid  (out_valid[k]),
            .out_ready  (out_ready),
            .out_block  (out_block[k]),
            .busy       (busy[k])
        );
    end

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // ---------------- reference model (byte-oriented FIPS-197) ----------------
    function automatic logic [7:0] gm(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        logic [7:0] y;
        p = 0; x = a; y = b;
        while (y != 0) begin
            if (y[0]) p = p ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
            y = y >> 1;
        end
        return p;
    endfunction

    function automatic logic [7:0] rl(input logic [7:0] x, input int n);
        logic [15:0] d;
        d = {x, x} << n;
        return d[15:8];
    endfunction

    task automatic build_sbox();
        logic [7:0] p, q, x;
        p = 8'h01; q = 8'h01;
        do begin
            p = p ^ {p[6:0], 1'b0} ^ (p[7] ? 8'h1b : 8'h00);
            q = q ^ {q[6:0], 1'b0};
            q = q ^ {q[5:0], 2'b0};
            q = q ^ {q[3:0], 4'b0};
            if (q[7]) q = q ^ 8'h09;
            x = q ^ rl(q, 1) ^ rl(q, 2) ^ rl(q, 3) ^ rl(q, 4);
            sbx[p] = x ^ 8'h63;
        end while (p != 8'h01);
        sbx[0] = 8'h63;
        for (int i = 0; i < 256; i++) isbx[sbx[i]] = 8'(i);
    endtask

    function automatic logic [127:0] m_sub(input logic [127:0] v, input bit inv);
        logic [127:0] o;
        for (int i = 0; i < 16; i++) o[127-8*i -: 8] = inv ? isbx[v[127-8*i -: 8]] : sbx[v[127-8*i -: 8]];
        return o;
    endfunction

    function automatic logic [127:0] m_shift(input logic [127:0] v, input bit inv);
        logic [127:0] o;
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                o[127-8*(4*c+r) -: 8] = v[127-8*(4*((inv ? c - r + 4 : c + r) % 4)+r) -: 8];
        return o;
    endfunction

    function automatic logic [127:0] m_mix(input logic [127:0] v, input bit inv);
        logic [127:0] o;
        logic [7:0] cf [4];
        logic [7:0] acc;
        cf = inv ? '{8'd14, 8'd11, 8'd13, 8'd9} : '{8'd2, 8'd3, 8'd1, 8'd1};
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++) begin
                acc = 0;
                for (int j = 0; j < 4; j++) acc = acc ^ gm(cf[(j - r + 4) % 4], v[127-8*(4*c+j) -: 8]);
                o[127-8*(4*c+r) -: 8] = acc;
            end
        return o;
    endfunction

    task automatic expand(input logic [255:0] key, input int nrr);
        logic [31:0] w [60];
        logic [31:0] t;
        logic [7:0]  rcon;
        int nk;
        nk = nrr - 6; rcon = 8'h01;
        for (int i = 0; i < nk; i++) w[i] = key[255-32*i -: 32];
        for (int i = nk; i < 4 * (nrr + 1); i++) begin
            t = w[i-1];
            if (i % nk == 0) begin
                t = {t[23:0], t[31:24]};
                t = {sbx[t[31:24]], sbx[t[23:16]], sbx[t[15:8]], sbx[t[7:0]]} ^ {rcon, 24'h0};
                rcon = gm(rcon, 8'h02);
            end else if (nk > 6 && i % nk == 4) begin
                t = {sbx[t[31:24]], sbx[t[23:16]], sbx[t[15:8]], sbx[t[7:0]]};
            end
            w[i] = w[i-nk] ^ t;
        end
        for (int r = 0; r <= nrr; r++) rkeys[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    endtask

    // Encrypt is the textbook cipher; decrypt is the straightforward inverse cipher with raw keys.
    function automatic logic [127:0] ref_cipher(input logic [127:0] blk, input bit dec, input int nrr);
        logic [127:0] s;
        if (!dec) begin
            s = blk ^ rkeys[0];
            for (int r = 1; r <= nrr; r++) begin
                s = m_shift(m_sub(s, 0), 0);
                if (r < nrr) s = m_mix(s, 0);
                s = s ^ rkeys[r];
            end
        end else begin
            s = blk ^ rkeys[nrr];
            for (int r = nrr - 1; r >= 0; r--) begin
                s = m_sub(m_shift(s, 1), 1) ^ rkeys[r];
                if (r > 0) s = m_mix(s, 1);
            end
        end
        return s;
    endfunction

    task automatic load_rk(input bit dec, input int nrr);
        rk_bus = '0;
        for (int r = 0; r <= nrr; r++)
            rk_bus[128*r +: 128] = (dec && r > 0 && r < nrr) ? m_mix(rkeys[r], 1) : rkeys[r];
    endtask

    function automatic logic [127:0] rand128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic scramble();
        in_block   = rand128();
        in_decrypt = 1'($urandom_range(0, 1));
        for (int w = 0; w < 60; w++) rk_bus[32*w +: 32] = $urandom;
    endtask

    // Called #1 after a rising edge; leaves the bench #1 after the output handshake edge.
    task automatic run_block(input int k, input logic [127:0] blk, input bit dec, input logic [255:0] key,
                             input bit use_fixed, input logic [127:0] fixed, input int hold,
                             input bit scr, input string tag);
        int nrr;
        int lat;
        logic [127:0] exp;
        nrr = 10 + 2 * k;
        expand(key, nrr);
        exp = use_fixed ? fixed : ref_cipher(blk, dec, nrr);
        in_block = blk; in_decrypt = dec; load_rk(dec, nrr);
        out_ready = (hold == 0);
        chk({tag, "_in_ready"}, 128'(in_ready[k]), 128'd1);
        in_valid[k] = 1'b1;
        @(posedge clk); #1;
        in_valid[k] = 1'b0;
        chk({tag, "_busy"}, 128'(busy[k]), 128'd1);
        lat = 0;
        while (!out_valid[k] && lat < 40) begin
            if (scr) scramble();
            @(posedge clk); #1;
            lat++;
        end
        chk({tag, "_latency"}, 128'(lat), 128'(nrr));
        if (lat >= 40) return;
        chk({tag, "_block"}, out_block[k], exp);
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            chk({tag, "_hold_valid"}, 128'(out_valid[k]), 128'd1);
            chk({tag, "_hold_block"}, out_block[k], exp);
            chk({tag, "_hold_in_ready"}, 128'(in_ready[k]), 128'd0);
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        chk({tag, "_drain_valid"}, 128'(out_valid[k]), 128'd0);
        chk({tag, "_drain_in_ready"}, 128'(in_ready[k]), 128'd1);
    endtask

    logic [127:0] fips_ct [3];

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        logic seen;
        fips_ct[0] = FIPS_CT128; fips_ct[1] = FIPS_CT192; fips_ct[2] = FIPS_CT256;
        build_sbox();

        // reset state
        #12;
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("reset_out_valid%0d", k), 128'(out_valid[k]), 128'd0);
            chk($sformatf("reset_out_block%0d", k), out_block[k], 128'd0);
            chk($sformatf("reset_busy%0d", k), 128'(busy[k]), 128'd0);
            chk($sformatf("reset_in_ready%0d", k), 128'(in_ready[k]), 128'd1);
        end
        @(negedge clk) rst = 1'b0;
        @(posedge clk); #1;

        // FIPS-197 known answers, both directions, all key sizes
        for (int k = 0; k < 3; k++) begin
            run_block(k, FIPS_PT, 1'b0, FIPS_KEY, 1'b1, fips_ct[k], 0, 1'b0, $sformatf("fips_enc%0d", k));
            run_block(k, fips_ct[k], 1'b1, FIPS_KEY, 1'b1, FIPS_PT, 0, 1'b0, $sformatf("fips_dec%0d", k));
        end

        // backpressure, then back-to-back enc/dec
        run_block(0, rand128(), 1'b0, {rand128(), rand128()}, 1'b0, '0, 5, 1'b0, "bp_hold");
        run_block(0, rand128(), 1'b0, {rand128(), rand128()}, 1'b0, '0, 0, 1'b0, "b2b_enc");
        run_block(0, rand128(), 1'b1, {rand128(), rand128()}, 1'b0, '0, 0, 1'b0, "b2b_dec");

        // inputs churn every cycle after accept
        for (int k = 0; k < 3; k++)
            run_block(k, rand128(), 1'($urandom_range(0, 1)), {rand128(), rand128()}, 1'b0, '0, 1, 1'b1,
                      $sformatf("scramble%0d", k));

        // reset during round 4
        expand({rand128(), rand128()}, 10);
        in_block = rand128(); in_decrypt = 1'b0; load_rk(1'b0, 10);
        out_ready = 1'b1;
        in_valid[0] = 1'b1;
        @(posedge clk); #1;
        in_valid[0] = 1'b0;
        repeat (3) @(posedge clk);
        #2 rst = 1'b1;
        #1;
        chk("midrun_rst_out_valid", 128'(out_valid[0]), 128'd0);
        chk("midrun_rst_busy", 128'(busy[0]), 128'd0);
        chk("midrun_rst_in_ready", 128'(in_ready[0]), 128'd1);
        @(negedge clk) rst = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 12; i++) begin
            @(posedge clk); #1;
            seen = seen | out_valid[0];
        end
        chk("midrun_rst_no_output", 128'(seen), 128'd0);
        run_block(0, FIPS_PT, 1'b0, FIPS_KEY, 1'b1, FIPS_CT128, 0, 1'b0, "after_rst");

        // randomized blocks
        for (int n = 0; n < 9; n++)
            run_block($urandom_range(0, 2), rand128(), 1'($urandom_range(0, 1)), {rand128(), rand128()},
                      1'b0, '0, $urandom_range(0, 2), 1'b0, $sformatf("rnd%0d", n));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
